// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin request arbiter with registered one-hot grant
//
// Purpose: arbitrates up to N_REQ request lines into a registered, strictly
// one-hot (or all-zero) grant that feeds an 8x3 one-hot encoder
// (gnt[0]->din_a ... gnt[7]->din_h). Grants rotate fairly; every release is
// followed by at least one all-zero grant cycle.
//
// Optional feature macro: GRANT_TIMEOUT_EN (forced release after MAX_HOLD
// grant cycles, signalled by a one-cycle timeout pulse).
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   req     in   N_REQ  request lines
//   done    in   1      release strobe from the holder, sampled only in GRANT
//   gnt     out  N_REQ  registered one-hot grant, zero when idle
//   busy    out  1      high while a grant is held
//   timeout out  1      one-cycle pulse after a forced release
module rr_grant_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  localparam int PTR_W = $clog2(N_REQ);

  // Elaboration-time guard on the configuration.
  if (N_REQ != 8 || MAX_HOLD < 2 || MAX_HOLD > 31 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_grant_arbiter: unsupported N_REQ/MAX_HOLD/CNT_W combination");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;
  logic               release_req;

`ifdef GRANT_TIMEOUT_EN
  logic [CNT_W-1:0]   hold_cnt_q;
  // Counter holds the number of completed grant cycles; it is zero in the
  // first grant cycle, so hitting MAX_HOLD-1 means gnt has been high MAX_HOLD cycles.
  logic               hold_expired;
  assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

  // Rotating priority search starting at ptr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_q + PTR_W'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Holder releases on done or when its own request drops.
  assign release_req = done || ((req & gnt_q) == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + CNT_W'(1);
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d   = N_REQ'(1) << win;
          ptr_d   = win + PTR_W'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_req) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (hold_expired) begin
          gnt_d     = '0;
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    gnt  = gnt_q;
    busy = |gnt_q;
`ifdef GRANT_TIMEOUT_EN
    timeout = timeout_q;
`else
    timeout = 1'b0;
`endif
  end

`ifndef GRANT_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

`ifdef GRANT_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int errors;
  int checks;

  rr_grant_arbiter #(
    .N_REQ   (8),
    .MAX_HOLD(MH),
    .CNT_W   (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream 8x3 encoder view of the grant.
  function automatic int enc(input logic [7:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Advance one clock edge, then check grant, busy and timeout.
  task automatic step(input string tag, input logic [7:0] exp_gnt, input logic exp_to);
    @(posedge clk);
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".busy"}, 32'(busy), 32'(exp_gnt != 8'h00));
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // Reset held two cycles with all lines requesting.
    step("rst0", 8'h00, 1'b0);
    step("rst1", 8'h00, 1'b0);
    rst = 1'b0;
    step("first_grant", 8'h01, 1'b0);

    // Rotation with done held high: each grant lasts one cycle, one gap cycle.
    done = 1'b1;
    step("rot_rel0", 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("rot_g%0d", k), 8'(1 << (k % 8)), 1'b0);
      step($sformatf("rot_z%0d", k), 8'h00, 1'b0);
    end
    done = 1'b0;
    // ptr is now 1.

    // Single requester on line 2, held, then released by done.
    req = 8'h04;
    step("single_g", 8'h04, 1'b0);
    check("single_enc", 32'(enc(gnt)), 32'd2);
    for (int k = 0; k < 4; k++) step($sformatf("single_hold%0d", k), 8'h04, 1'b0);
    done = 1'b1;
    step("single_rel", 8'h00, 1'b0);
    done = 1'b0;
    // ptr is now 3.

    // Fairness skip: from ptr=3, line 7 wins before line 1.
    req = 8'h82;
    step("skip_g7", 8'h80, 1'b0);
    done = 1'b1;
    step("skip_rel", 8'h00, 1'b0);
    done = 1'b0;
    step("skip_g1", 8'h02, 1'b0);
    // ptr is now 2; line 1 holds.

    // Request drop releases; then line 5 wins and is not preempted.
    req = 8'h20;
    step("drop1_rel", 8'h00, 1'b0);
    step("g5", 8'h20, 1'b0);
    req = 8'h21;
    step("no_preempt", 8'h20, 1'b0);
    req = 8'h01;
    step("drop5_rel", 8'h00, 1'b0);
    step("g0_after5", 8'h01, 1'b0);

    // Reset mid-grant clears gnt and ptr at that edge.
    rst = 1'b1;
    req = 8'h03;
    step("rst_in_grant", 8'h00, 1'b0);
    rst = 1'b0;
    step("ptr_reset", 8'h01, 1'b0);
    done = 1'b1;
    step("pre_hold_rel", 8'h00, 1'b0);
    done = 1'b0;
    // ptr is now 1.

    // Long hold on line 4.
    req = 8'h10;
    step("hold_g", 8'h10, 1'b0);
`ifdef GRANT_TIMEOUT_EN
    for (int k = 1; k < MH; k++) step($sformatf("to_hold%0d", k), 8'h10, 1'b0);
    step("to_pulse", 8'h00, 1'b1);
    step("to_regrant", 8'h10, 1'b0);
    for (int k = 1; k < MH - 1; k++) step($sformatf("to_hold2_%0d", k), 8'h10, 1'b0);
    done = 1'b1;
    step("to_done_wins", 8'h00, 1'b0);
    done = 1'b0;
`else
    for (int k = 1; k < 24; k++) step($sformatf("hold%0d", k), 8'h10, 1'b0);
    done = 1'b1;
    step("hold_rel", 8'h00, 1'b0);
    done = 1'b0;
`endif

    // done while idle is ignored.
    req  = 8'h00;
    done = 1'b1;
    step("idle_done", 8'h00, 1'b0);
    done = 1'b0;
    step("idle_stay", 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
